rename_stage: RTL and testbench

- Parametrised N-wide rename stage placed between the decoder array and dispatch.
- Renames up to ID_WIDTH uops per cycle: multi-pop from the free list, intra-bundle RAW bypass, WAW-filtered RAT writes, ROB allocation.
- Registers the renamed bundle in an output pipeline register with a valid/ready handshake.
- Generalises the single-slot rename: every slot is renamed, not only slot 0.

---
 rtl/rename_stage_pkg.sv | 19 +
 rtl/rename_bypass.sv | 91 +++++++++
 rtl/rename_stage.sv | 200 ++++++++++++++++++++
 tb/tb_rename_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_stage_pkg.sv
// Shared rename-stage configuration: default CPU widths and the canonical renamed-slot layout.
package rename_stage_pkg;

  localparam int unsigned CPU_ID_WIDTH = 2;
  localparam int unsigned CPU_ARF_IDX  = 5;
  localparam int unsigned CPU_PRF_IDX  = 6;
  localparam int unsigned CPU_ROB_IDX  = 5;

  typedef struct packed {
    logic                   valid;
    logic [CPU_PRF_IDX-1:0] rd_phy;
    logic [CPU_PRF_IDX-1:0] rs1_phy;
    logic [CPU_PRF_IDX-1:0] rs2_phy;
    logic                   rs1_valid;
    logic                   rs2_valid;
    logic [CPU_ROB_IDX-1:0] rob_id;
  } rename_slot_t;

endpackage

// File: rtl/rename_bypass.sv
// Combinational rename network for one bundle: free-list slot assignment,
// intra-bundle RAW bypass of sources and WAW "last writer" detection.
module rename_bypass
  import rename_stage_pkg::*;
#(
  parameter  int unsigned ID_WIDTH = CPU_ID_WIDTH,
  parameter  int unsigned ARF_IDX  = CPU_ARF_IDX,
  parameter  int unsigned PRF_IDX  = CPU_PRF_IDX,
  localparam int unsigned CNT_W    = $clog2(ID_WIDTH + 1)
) (
  input  logic [ID_WIDTH-1:0]           slot_valid_i,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   rd_arch_i,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   rs1_arch_i,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   rs2_arch_i,
  input  logic [2*ID_WIDTH*PRF_IDX-1:0] rat_phy_i,
  input  logic [2*ID_WIDTH-1:0]         rat_valid_i,
  input  logic [ID_WIDTH*PRF_IDX-1:0]   free_idx_i,
  output logic [CNT_W-1:0]              need_cnt_o,
  output logic [ID_WIDTH*PRF_IDX-1:0]   rd_phy_o,
  output logic [ID_WIDTH*PRF_IDX-1:0]   rs1_phy_o,
  output logic [ID_WIDTH*PRF_IDX-1:0]   rs2_phy_o,
  output logic [ID_WIDTH-1:0]           rs1_valid_o,
  output logic [ID_WIDTH-1:0]           rs2_valid_o,
  output logic [ID_WIDTH-1:0]           last_writer_o
);

  logic [ID_WIDTH-1:0]         need;
  logic [ID_WIDTH*PRF_IDX-1:0] rd_phy;
  logic [CNT_W-1:0]            cnt;

  // Needing slots consume free entries in slot order, oldest free register first.
  always_comb begin
    need   = '0;
    rd_phy = '0;
    cnt    = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      need[i] = slot_valid_i[i] && (rd_arch_i[i*ARF_IDX +: ARF_IDX] != '0);
      if (need[i]) begin
        rd_phy[i*PRF_IDX +: PRF_IDX] = free_idx_i[cnt*PRF_IDX +: PRF_IDX];
        cnt = cnt + 1'b1;
      end
    end
  end

  assign need_cnt_o = cnt;
  assign rd_phy_o   = rd_phy;

  // Ascending scan over older slots lets the youngest matching producer win.
  always_comb begin
    rs1_phy_o   = '0;
    rs2_phy_o   = '0;
    rs1_valid_o = '0;
    rs2_valid_o = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      rs1_phy_o[i*PRF_IDX +: PRF_IDX] = rat_phy_i[(2*i)*PRF_IDX +: PRF_IDX];
      rs1_valid_o[i]                  = rat_valid_i[2*i];
      rs2_phy_o[i*PRF_IDX +: PRF_IDX] = rat_phy_i[(2*i+1)*PRF_IDX +: PRF_IDX];
      rs2_valid_o[i]                  = rat_valid_i[2*i+1];
      for (int unsigned j = 0; j < i; j++) begin
        if (need[j] && rd_arch_i[j*ARF_IDX +: ARF_IDX] == rs1_arch_i[i*ARF_IDX +: ARF_IDX]) begin
          rs1_phy_o[i*PRF_IDX +: PRF_IDX] = rd_phy[j*PRF_IDX +: PRF_IDX];
          rs1_valid_o[i]                  = 1'b0;
        end
        if (need[j] && rd_arch_i[j*ARF_IDX +: ARF_IDX] == rs2_arch_i[i*ARF_IDX +: ARF_IDX]) begin
          rs2_phy_o[i*PRF_IDX +: PRF_IDX] = rd_phy[j*PRF_IDX +: PRF_IDX];
          rs2_valid_o[i]                  = 1'b0;
        end
      end
      if (rs1_arch_i[i*ARF_IDX +: ARF_IDX] == '0) begin
        rs1_phy_o[i*PRF_IDX +: PRF_IDX] = '0;
        rs1_valid_o[i]                  = 1'b1;
      end
      if (rs2_arch_i[i*ARF_IDX +: ARF_IDX] == '0) begin
        rs2_phy_o[i*PRF_IDX +: PRF_IDX] = '0;
        rs2_valid_o[i]                  = 1'b1;
      end
    end
  end

  always_comb begin
    last_writer_o = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      last_writer_o[i] = need[i];
      for (int unsigned j = i + 1; j < ID_WIDTH; j++) begin
        if (need[j] && rd_arch_i[j*ARF_IDX +: ARF_IDX] == rd_arch_i[i*ARF_IDX +: ARF_IDX])
          last_writer_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// N-wide rename stage with registered output bundle (rst is active-low, asynchronous).
// Define RENAME_SKID_EN to replace the output register with a 2-entry skid buffer.
module rename_stage
  import rename_stage_pkg::*;
#(
  parameter  int unsigned ID_WIDTH = CPU_ID_WIDTH,
  parameter  int unsigned ARF_IDX  = CPU_ARF_IDX,
  parameter  int unsigned PRF_IDX  = CPU_PRF_IDX,
  parameter  int unsigned ROB_IDX  = CPU_ROB_IDX,
  localparam int unsigned CNT_W    = $clog2(ID_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ID_WIDTH-1:0]           in_slot_valid,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   in_rd_arch,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   in_rs1_arch,
  input  logic [ID_WIDTH*ARF_IDX-1:0]   in_rs2_arch,
  output logic [2*ID_WIDTH*ARF_IDX-1:0] rat_read_arch,
  input  logic [2*ID_WIDTH*PRF_IDX-1:0] rat_read_phy,
  input  logic [2*ID_WIDTH-1:0]         rat_read_valid,
  output logic [ID_WIDTH-1:0]           rat_write_en,
  output logic [ID_WIDTH*ARF_IDX-1:0]   rat_write_arch,
  output logic [ID_WIDTH*PRF_IDX-1:0]   rat_write_phy,
  input  logic [ID_WIDTH*PRF_IDX-1:0]   fl_free_idx,
  input  logic [CNT_W-1:0]              fl_avail,
  output logic [CNT_W-1:0]              fl_pop_cnt,
  input  logic                          rob_ready,
  output logic                          rob_alloc,
  input  logic [ID_WIDTH*ROB_IDX-1:0]   rob_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_slot_valid,
  output logic [ID_WIDTH*PRF_IDX-1:0]   out_rd_phy,
  output logic [ID_WIDTH*PRF_IDX-1:0]   out_rs1_phy,
  output logic [ID_WIDTH*PRF_IDX-1:0]   out_rs2_phy,
  output logic [ID_WIDTH-1:0]           out_rs1_valid,
  output logic [ID_WIDTH-1:0]           out_rs2_valid,
  output logic [ID_WIDTH*ROB_IDX-1:0]   out_rob_id
);

  typedef struct packed {
    logic               valid;
    logic [PRF_IDX-1:0] rd_phy;
    logic [PRF_IDX-1:0] rs1_phy;
    logic [PRF_IDX-1:0] rs2_phy;
    logic               rs1_valid;
    logic               rs2_valid;
    logic [ROB_IDX-1:0] rob_id;
  } slot_t;

  logic [CNT_W-1:0]            need_cnt;
  logic [ID_WIDTH*PRF_IDX-1:0] rd_phy, rs1_phy, rs2_phy;
  logic [ID_WIDTH-1:0]         rs1_valid, rs2_valid, last_writer;
  slot_t [ID_WIDTH-1:0]        new_bundle;
  slot_t [ID_WIDTH-1:0]        head;
  logic                        head_valid;
  logic                        space_ok;
  logic                        accept;

  rename_bypass #(
    .ID_WIDTH (ID_WIDTH),
    .ARF_IDX  (ARF_IDX),
    .PRF_IDX  (PRF_IDX)
  ) u_bypass (
    .slot_valid_i  (in_slot_valid),
    .rd_arch_i     (in_rd_arch),
    .rs1_arch_i    (in_rs1_arch),
    .rs2_arch_i    (in_rs2_arch),
    .rat_phy_i     (rat_read_phy),
    .rat_valid_i   (rat_read_valid),
    .free_idx_i    (fl_free_idx),
    .need_cnt_o    (need_cnt),
    .rd_phy_o      (rd_phy),
    .rs1_phy_o     (rs1_phy),
    .rs2_phy_o     (rs2_phy),
    .rs1_valid_o   (rs1_valid),
    .rs2_valid_o   (rs2_valid),
    .last_writer_o (last_writer)
  );

  always_comb begin
    rat_read_arch = '0;
    new_bundle    = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      rat_read_arch[(2*i)*ARF_IDX +: ARF_IDX]   = in_rs1_arch[i*ARF_IDX +: ARF_IDX];
      rat_read_arch[(2*i+1)*ARF_IDX +: ARF_IDX] = in_rs2_arch[i*ARF_IDX +: ARF_IDX];
      new_bundle[i].valid     = in_slot_valid[i];
      new_bundle[i].rd_phy    = rd_phy[i*PRF_IDX +: PRF_IDX];
      new_bundle[i].rs1_phy   = rs1_phy[i*PRF_IDX +: PRF_IDX];
      new_bundle[i].rs2_phy   = rs2_phy[i*PRF_IDX +: PRF_IDX];
      new_bundle[i].rs1_valid = rs1_valid[i];
      new_bundle[i].rs2_valid = rs2_valid[i];
      new_bundle[i].rob_id    = rob_id[i*ROB_IDX +: ROB_IDX];
    end
  end

  // All side effects are gated by one accept so a stalled bundle never partially allocates.
  assign accept         = in_valid && !flush && rob_ready && (fl_avail >= need_cnt) && space_ok;
  assign in_ready       = accept;
  assign rob_alloc      = accept;
  assign fl_pop_cnt     = accept ? need_cnt : '0;
  assign rat_write_en   = accept ? last_writer : '0;
  assign rat_write_arch = in_rd_arch;
  assign rat_write_phy  = rd_phy;

`ifdef RENAME_SKID_EN
  slot_t [ID_WIDTH-1:0] buf_q [2];
  slot_t [ID_WIDTH-1:0] buf_d [2];
  logic [1:0]           cnt_q, cnt_d;
  logic                 pop;

  // in_ready depends only on occupancy, never on out_ready.
  assign space_ok   = (cnt_q != 2'd2);
  assign pop        = (cnt_q != 2'd0) && out_ready;
  assign head_valid = (cnt_q != 2'd0);
  assign head       = buf_q[0];

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (flush) begin
      buf_d = '{default: '0};
      cnt_d = '0;
    end else begin
      if (pop) begin
        buf_d[0] = buf_q[1];
        buf_d[1] = '0;
        cnt_d    = cnt_q - 2'd1;
      end
      if (accept) begin
        buf_d[cnt_d[0]] = new_bundle;
        cnt_d           = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
`else
  slot_t [ID_WIDTH-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  assign space_ok   = !out_valid_q || out_ready;
  assign head_valid = out_valid_q;
  assign head       = out_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush || (!accept && out_ready)) begin
      out_valid_d = 1'b0;
      out_d       = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = new_bundle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
`endif

  always_comb begin
    out_valid      = head_valid;
    out_slot_valid = '0;
    out_rd_phy     = '0;
    out_rs1_phy    = '0;
    out_rs2_phy    = '0;
    out_rs1_valid  = '0;
    out_rs2_valid  = '0;
    out_rob_id     = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      out_slot_valid[i]                 = head[i].valid;
      out_rd_phy[i*PRF_IDX +: PRF_IDX]  = head[i].rd_phy;
      out_rs1_phy[i*PRF_IDX +: PRF_IDX] = head[i].rs1_phy;
      out_rs2_phy[i*PRF_IDX +: PRF_IDX] = head[i].rs2_phy;
      out_rs1_valid[i]                  = head[i].rs1_valid;
      out_rs2_valid[i]                  = head[i].rs2_valid;
      out_rob_id[i*ROB_IDX +: ROB_IDX]  = head[i].rob_id;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage (2-wide, default widths, single output register).
module tb_rename_stage;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [1:0]  in_slot_valid;
  logic [9:0]  in_rd_arch, in_rs1_arch, in_rs2_arch;
  logic [19:0] rat_read_arch;
  logic [23:0] rat_read_phy;
  logic [3:0]  rat_read_valid;
  logic [1:0]  rat_write_en;
  logic [9:0]  rat_write_arch;
  logic [11:0] rat_write_phy;
  logic [11:0] fl_free_idx;
  logic [1:0]  fl_avail, fl_pop_cnt;
  logic        rob_ready, rob_alloc;
  logic [9:0]  rob_id;
  logic        out_valid, out_ready;
  logic [1:0]  out_slot_valid;
  logic [11:0] out_rd_phy, out_rs1_phy, out_rs2_phy;
  logic [1:0]  out_rs1_valid, out_rs2_valid;
  logic [9:0]  out_rob_id;

  rename_stage #(.ID_WIDTH(2), .ARF_IDX(5), .PRF_IDX(6), .ROB_IDX(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_rd_arch(in_rd_arch), .in_rs1_arch(in_rs1_arch),
    .in_rs2_arch(in_rs2_arch), .rat_read_arch(rat_read_arch), .rat_read_phy(rat_read_phy),
    .rat_read_valid(rat_read_valid), .rat_write_en(rat_write_en), .rat_write_arch(rat_write_arch),
    .rat_write_phy(rat_write_phy), .fl_free_idx(fl_free_idx), .fl_avail(fl_avail),
    .fl_pop_cnt(fl_pop_cnt), .rob_ready(rob_ready), .rob_alloc(rob_alloc), .rob_id(rob_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot_valid(out_slot_valid),
    .out_rd_phy(out_rd_phy), .out_rs1_phy(out_rs1_phy), .out_rs2_phy(out_rs2_phy),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_rob_id(out_rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // stimulus state
  logic       s_inv, s_flush, s_robr, s_outr;
  logic [1:0] s_sv, s_avail;
  logic [3:0] s_rvld;
  logic [4:0] s_rd [2], s_rs1 [2], s_rs2 [2], s_rob [2];
  logic [5:0] s_fl [2], s_rphy [4];

  task automatic drive();
    in_valid = s_inv; in_slot_valid = s_sv; flush = s_flush;
    rob_ready = s_robr; out_ready = s_outr; fl_avail = s_avail; rat_read_valid = s_rvld;
    for (int i = 0; i < 2; i++) begin
      in_rd_arch[i*5 +: 5]  = s_rd[i];
      in_rs1_arch[i*5 +: 5] = s_rs1[i];
      in_rs2_arch[i*5 +: 5] = s_rs2[i];
      fl_free_idx[i*6 +: 6] = s_fl[i];
      rob_id[i*5 +: 5]      = s_rob[i];
    end
    for (int k = 0; k < 4; k++) rat_read_phy[k*6 +: 6] = s_rphy[k];
  endtask

  // reference model
  typedef struct packed {
    logic [1:0]  sv;
    logic [11:0] rd, rs1, rs2;
    logic [1:0]  v1, v2;
    logic [9:0]  rob;
  } bund_t;

  bund_t      m_out, m_new;
  logic       m_valid, m_acc;
  logic [1:0] m_pop, m_wen;

  // Pending map: arch -> phy produced by an older slot of the same bundle.
  task automatic model_comb();
    bit         pend [32];
    logic [5:0] pphy [32];
    logic [1:0] need;
    logic [4:0] arch;
    logic [5:0] p;
    logic       v;
    int         n;
    for (int a = 0; a < 32; a++) begin pend[a] = 0; pphy[a] = '0; end
    m_new = '0; need = '0; n = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        arch = (k == 0) ? s_rs1[i] : s_rs2[i];
        if (arch == 0)       begin p = '0;         v = 1'b1; end
        else if (pend[arch]) begin p = pphy[arch]; v = 1'b0; end
        else                 begin p = s_rphy[2*i+k]; v = s_rvld[2*i+k]; end
        if (k == 0) begin m_new.rs1[i*6 +: 6] = p; m_new.v1[i] = v; end
        else        begin m_new.rs2[i*6 +: 6] = p; m_new.v2[i] = v; end
      end
      if (s_sv[i] && s_rd[i] != 0) begin
        need[i] = 1'b1;
        m_new.rd[i*6 +: 6] = s_fl[n];
        pend[s_rd[i]] = 1;
        pphy[s_rd[i]] = s_fl[n];
        n++;
      end
      m_new.rob[i*5 +: 5] = s_rob[i];
    end
    m_new.sv = s_sv;
    m_wen = need;
    for (int i = 0; i < 2; i++)
      for (int j = i + 1; j < 2; j++)
        if (need[i] && need[j] && s_rd[i] == s_rd[j]) m_wen[i] = 1'b0;
    m_pop = 2'(n);
    m_acc = s_inv && !s_flush && s_robr && (int'(s_avail) >= n) && (!m_valid || s_outr);
  endtask

  task automatic step_pre();
    drive();
    #1;
    model_comb();
    chk("in_ready", 64'(in_ready), 64'(m_acc));
    chk("rob_alloc", 64'(rob_alloc), 64'(m_acc));
    chk("fl_pop_cnt", 64'(fl_pop_cnt), m_acc ? 64'(m_pop) : 64'd0);
    chk("rat_write_en", 64'(rat_write_en), m_acc ? 64'(m_wen) : 64'd0);
    chk("rat_read_arch", 64'(rat_read_arch), 64'({s_rs2[1], s_rs1[1], s_rs2[0], s_rs1[0]}));
    for (int i = 0; i < 2; i++)
      if (m_acc && m_wen[i]) begin
        chk("rat_write_arch", 64'(rat_write_arch[i*5 +: 5]), 64'(s_rd[i]));
        chk("rat_write_phy", 64'(rat_write_phy[i*6 +: 6]), 64'(m_new.rd[i*6 +: 6]));
      end
  endtask

  task automatic step_post();
    @(posedge clk);
    if (s_flush)     begin m_valid = 1'b0; m_out = '0; end
    else if (m_acc)  begin m_valid = 1'b1; m_out = m_new; end
    else if (s_outr) begin m_valid = 1'b0; m_out = '0; end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_bundle", 64'({out_slot_valid, out_rd_phy, out_rs1_phy, out_rs2_phy,
                           out_rs1_valid, out_rs2_valid, out_rob_id}), 64'(m_out));
  endtask

  task automatic set_bundle(input int rd0, rd1, a0, a1, b0, b1, f0, f1);
    s_rd[0] = 5'(rd0); s_rd[1] = 5'(rd1);
    s_rs1[0] = 5'(a0); s_rs1[1] = 5'(a1);
    s_rs2[0] = 5'(b0); s_rs2[1] = 5'(b1);
    s_fl[0] = 6'(f0);  s_fl[1] = 6'(f1);
    for (int i = 0; i < 2; i++) begin
      s_rphy[2*i]   = {1'b1, s_rs1[i]};
      s_rphy[2*i+1] = {1'b1, s_rs2[i]};
      s_rob[i]      = 5'(2*i + 3);
    end
    s_rvld = 4'hF;
  endtask

  typedef struct {
    int inv, sv, rd0, rd1, a0, a1, b0, b1, f0, f1, avail, robr;
    int acc, pop, wen, rdp0, rdp1, s1p1, s1v1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // RAT mapping in the table is arch+32, always ready.
    vecs[0] = '{1, 3, 5, 6, 0, 5, 0, 1, 12, 13, 2, 1,  1, 2, 3, 12, 13, 12, 0};
    vecs[1] = '{1, 3, 0, 7, 3, 0, 0, 0, 20, 21, 2, 1,  1, 1, 2,  0, 20,  0, 1};
    vecs[2] = '{1, 3, 9, 9, 1, 9, 0, 0, 30, 31, 2, 1,  1, 2, 2, 30, 31, 30, 0};
    vecs[3] = '{1, 3, 5, 6, 0, 5, 0, 1, 12, 13, 1, 1,  0, 0, 0,  0,  0,  0, 0};
    vecs[4] = '{1, 1, 4, 8, 0, 4, 0, 0, 40, 41, 2, 1,  1, 1, 1, 40,  0, 40, 0};
    vecs[5] = '{1, 2, 3, 2, 0, 3, 0, 0, 50, 51, 2, 1,  1, 1, 2,  0, 50, 35, 1};
    vecs[6] = '{0, 3, 5, 6, 0, 5, 0, 1, 12, 13, 2, 1,  0, 0, 0,  0,  0,  0, 0};
    vecs[7] = '{1, 3, 5, 6, 0, 5, 0, 1, 12, 13, 2, 0,  0, 0, 0,  0,  0,  0, 0};
    vecs[8] = '{1, 3, 0, 0, 2, 0, 0, 0,  1,  2, 0, 1,  1, 0, 0,  0,  0,  0, 1};

    s_inv = 0; s_flush = 0; s_robr = 0; s_outr = 0; s_sv = 0; s_avail = 0;
    set_bundle(0, 0, 0, 0, 0, 0, 0, 0);
    m_valid = 0; m_out = '0;
    drive();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_bundle", 64'({out_slot_valid, out_rd_phy, out_rs1_phy, out_rs2_phy,
                                 out_rs1_valid, out_rs2_valid, out_rob_id}), 64'd0);
    chk("reset_rob_alloc", 64'(rob_alloc), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int t = 0; t < 9; t++) begin
      s_inv = 1'(vecs[t].inv); s_sv = 2'(vecs[t].sv); s_avail = 2'(vecs[t].avail);
      s_robr = 1'(vecs[t].robr); s_outr = 1'b1; s_flush = 1'b0;
      set_bundle(vecs[t].rd0, vecs[t].rd1, vecs[t].a0, vecs[t].a1,
                 vecs[t].b0, vecs[t].b1, vecs[t].f0, vecs[t].f1);
      step_pre();
      chk($sformatf("vec%0d_in_ready", t), 64'(in_ready), 64'(vecs[t].acc));
      chk($sformatf("vec%0d_pop", t), 64'(fl_pop_cnt), 64'(vecs[t].pop));
      chk($sformatf("vec%0d_wen", t), 64'(rat_write_en), 64'(vecs[t].wen));
      if (vecs[t].wen == 2 || vecs[t].wen == 3)
        chk($sformatf("vec%0d_wphy1", t), 64'(rat_write_phy[11:6]), 64'(vecs[t].rdp1));
      step_post();
      chk($sformatf("vec%0d_out_valid", t), 64'(out_valid), 64'(vecs[t].acc));
      chk($sformatf("vec%0d_rd_phy", t), 64'(out_rd_phy), 64'({6'(vecs[t].rdp1), 6'(vecs[t].rdp0)}));
      chk($sformatf("vec%0d_rs1_phy1", t), 64'(out_rs1_phy[11:6]), 64'(vecs[t].s1p1));
      chk($sformatf("vec%0d_rs1_valid1", t), 64'(out_rs1_valid[1]), 64'(vecs[t].s1v1));
    end

    // free-list stall, then accept once enough entries exist
    s_inv = 1; s_sv = 2'b11; s_robr = 1; s_outr = 1; s_flush = 0; s_avail = 2'd1;
    set_bundle(5, 6, 0, 5, 0, 1, 12, 13);
    step_pre();
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_pop", 64'(fl_pop_cnt), 64'd0);
    chk("stall_alloc", 64'(rob_alloc), 64'd0);
    step_post();
    s_avail = 2'd2;
    step_pre();
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    step_post();
    chk("unstall_out_valid", 64'(out_valid), 64'd1);
    chk("unstall_rd_phy", 64'(out_rd_phy), 64'({6'd13, 6'd12}));

    // backpressure hold, then back-to-back transfer
    s_outr = 0;
    set_bundle(7, 8, 0, 0, 0, 0, 44, 45);
    for (int c = 0; c < 3; c++) begin
      step_pre();
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_pop", 64'(fl_pop_cnt), 64'd0);
      step_post();
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_rd_phy", 64'(out_rd_phy), 64'({6'd13, 6'd12}));
    end
    s_outr = 1;
    step_pre();
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    chk("b2b_pop", 64'(fl_pop_cnt), 64'd2);
    step_post();
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_rd_phy", 64'(out_rd_phy), 64'({6'd45, 6'd44}));

    // flush beats out_ready and blocks accept
    s_flush = 1;
    step_pre();
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_pop", 64'(fl_pop_cnt), 64'd0);
    step_post();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    s_flush = 0;

    // randomized against the model
    for (int c = 0; c < 400; c++) begin
      s_inv = ($urandom % 8) != 0;
      s_sv = 2'($urandom);
      s_robr = ($urandom % 6) != 0;
      s_outr = ($urandom % 4) != 0;
      s_flush = ($urandom % 16) == 0;
      s_avail = 2'($urandom_range(0, 2));
      s_rvld = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        s_rd[i]  = 5'($urandom_range(0, 3));
        s_rs1[i] = 5'($urandom_range(0, 3));
        s_rs2[i] = 5'($urandom_range(0, 3));
        s_fl[i]  = 6'($urandom_range(1, 63));
        s_rob[i] = 5'($urandom);
      end
      for (int k = 0; k < 4; k++) s_rphy[k] = 6'($urandom);
      step_pre();
      step_post();
    end

    // asynchronous reset in the middle of a held bundle
    s_inv = 1; s_sv = 2'b11; s_robr = 1; s_outr = 1; s_flush = 0; s_avail = 2'd2;
    set_bundle(5, 6, 0, 5, 0, 1, 12, 13);
    step_pre();
    step_post();
    chk("prerst_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_bundle", 64'({out_slot_valid, out_rd_phy, out_rs1_phy, out_rs2_phy,
                                 out_rs1_valid, out_rs2_valid, out_rob_id}), 64'd0);
    m_valid = 0; m_out = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step_pre();
    step_post();
    chk("post_rst_rd_phy", 64'(out_rd_phy), 64'({6'd13, 6'd12}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
